// File: rtl/mouse_cell_encoder_pkg.sv
// Shared types, widths and cursor arithmetic helpers for the mouse cell encoder.
package mouse_cell_pkg;

    typedef enum logic [1:0] {IDLE, MOVE, DIV, EMIT} state_t;

    localparam int CELL_IDX_W = 11;
    localparam int CUR_X_W    = 8;
    localparam int CUR_Y_W    = 7;
    localparam int DELTA_W    = 9;
    localparam int SUM_W      = 11;

    typedef logic signed [SUM_W-1:0] sum_t;

    function automatic sum_t clamp_range(input sum_t v, input sum_t lo, input sum_t hi);
        sum_t r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Delta is limited to one extent so a single add/subtract brings the sum back in range.
    function automatic sum_t wrap_range(input sum_t cur, input sum_t delta, input sum_t ext);
        sum_t d;
        sum_t s;
        d = clamp_range(delta, -(ext - 11'sd1), ext - 11'sd1);
        s = cur + d;
        if (s < 11'sd0) begin
            s = s + ext;
        end else if (s >= ext) begin
            s = s - ext;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/mouse_cell_encoder_if.sv
// Mouse packet handshake bus between the packet receiver (master) and the encoder (slave).
interface mouse_cell_encoder_if;
    import mouse_cell_pkg::*;

    logic               pkt_valid;
    logic               pkt_ready;
    logic [DELTA_W-1:0] pkt_dx;
    logic [DELTA_W-1:0] pkt_dy;
    logic               pkt_left;

    modport master (output pkt_valid, output pkt_dx, output pkt_dy, output pkt_left,
                    input  pkt_ready);
    modport slave  (input  pkt_valid, input  pkt_dx, input  pkt_dy, input  pkt_left,
                    output pkt_ready);
endinterface

// File: rtl/mouse_cell_encoder_divider.sv
// Sequential quotient by repeated subtraction of CELL_SIZE, one step per cycle.
module cell_divider #(
    parameter int W         = 8,
    parameter int QW        = 8,
    parameter int CELL_SIZE = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam logic [W-1:0]  STEP  = W'(CELL_SIZE);
    localparam logic [QW-1:0] Q_ONE = QW'(1);

    logic [W-1:0]  r_rem;
    logic [QW-1:0] r_quot;
    logic          w_done;

    assign w_done   = (r_rem < STEP);
    assign done     = w_done;
    assign quotient = r_quot;

    // Load on start, otherwise subtract until the remainder drops below one cell.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rem  <= '0;
            r_quot <= '0;
        end else if (start) begin
            r_rem  <= dividend;
            r_quot <= '0;
        end else if (!w_done) begin
            r_rem  <= r_rem - STEP;
            r_quot <= r_quot + Q_ONE;
        end else begin
            r_rem  <= r_rem;
            r_quot <= r_quot;
        end
    end
endmodule

// File: rtl/mouse_cell_encoder.sv
// Mouse packet to board cell encoder: moves a cursor and emits mouseCell/mouseToggle.
// Define MOUSE_CURSOR_WRAP_EN to wrap the cursor at the board edges instead of clamping.
module mouse_cell_encoder
    import mouse_cell_pkg::*;
#(
    parameter int BOARD_HEIGHT = 3,
    parameter int BOARD_LENGTH = 3,
    parameter int CELL_SIZE    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    mouse_cell_encoder_if.slave   pkt,
    output logic [CUR_X_W-1:0]    cursor_x,
    output logic [CUR_Y_W-1:0]    cursor_y,
    output logic [CELL_IDX_W-1:0] mouseCell,
    output logic                  mouseToggle,
    output logic                  busy
);
    localparam sum_t X_EXT_S = sum_t'(BOARD_LENGTH * CELL_SIZE);
    localparam sum_t Y_EXT_S = sum_t'(BOARD_HEIGHT * CELL_SIZE);

    state_t               r_state;
    state_t               w_next;
    logic [DELTA_W-1:0]   r_dx;
    logic [DELTA_W-1:0]   r_dy;
    logic                 r_left;
    logic                 r_prev_left;
    logic [CUR_X_W-1:0]   r_cursor_x;
    logic [CUR_Y_W-1:0]   r_cursor_y;
    logic [CELL_IDX_W-1:0] r_mouse_cell;
    logic                 r_toggle;
    logic                 r_busy;
    logic                 r_pkt_ready;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_x_done;
    logic                 w_y_done;
    logic [CUR_X_W-1:0]   w_col;
    logic [CUR_Y_W-1:0]   w_row;
    sum_t                 w_cx;
    sum_t                 w_cy;
    sum_t                 w_dx;
    sum_t                 w_dy;
    logic [CUR_X_W-1:0]   w_nx;
    logic [CUR_Y_W-1:0]   w_ny;

    assign w_accept = (r_state == IDLE) && pkt.pkt_valid;
    assign w_start  = (r_state == MOVE);

    assign pkt.pkt_ready = r_pkt_ready;
    assign cursor_x      = r_cursor_x;
    assign cursor_y      = r_cursor_y;
    assign mouseCell     = r_mouse_cell;
    assign mouseToggle   = r_toggle;
    assign busy          = r_busy;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = MOVE;
                end else begin
                    w_next = IDLE;
                end
            end
            MOVE: w_next = DIV;
            DIV: begin
                if (w_x_done && w_y_done) begin
                    w_next = EMIT;
                end else begin
                    w_next = DIV;
                end
            end
            EMIT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Screen Y grows downward while the mouse reports positive dy as up, hence the subtraction.
    always_comb begin
        w_cx = $signed({3'b000, r_cursor_x});
        w_cy = $signed({4'b0000, r_cursor_y});
        w_dx = $signed({{2{r_dx[DELTA_W-1]}}, r_dx});
        w_dy = $signed({{2{r_dy[DELTA_W-1]}}, r_dy});
`ifdef MOUSE_CURSOR_WRAP_EN
        w_nx = CUR_X_W'(wrap_range(w_cx, w_dx, X_EXT_S));
        w_ny = CUR_Y_W'(wrap_range(w_cy, -w_dy, Y_EXT_S));
`else
        w_nx = CUR_X_W'(clamp_range(w_cx + w_dx, 11'sd0, X_EXT_S - 11'sd1));
        w_ny = CUR_Y_W'(clamp_range(w_cy - w_dy, 11'sd0, Y_EXT_S - 11'sd1));
`endif
    end

    cell_divider #(.W(CUR_X_W), .QW(CUR_X_W), .CELL_SIZE(CELL_SIZE)) u_div_x (
        .clock    (clock),
        .reset    (reset),
        .start    (w_start),
        .dividend (w_nx),
        .done     (w_x_done),
        .quotient (w_col)
    );

    cell_divider #(.W(CUR_Y_W), .QW(CUR_Y_W), .CELL_SIZE(CELL_SIZE)) u_div_y (
        .clock    (clock),
        .reset    (reset),
        .start    (w_start),
        .dividend (w_ny),
        .done     (w_y_done),
        .quotient (w_row)
    );

    // Datapath: packet latch, cursor update, cell/toggle publish on EMIT entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dx         <= '0;
            r_dy         <= '0;
            r_left       <= 1'b0;
            r_prev_left  <= 1'b0;
            r_cursor_x   <= '0;
            r_cursor_y   <= '0;
            r_mouse_cell <= '0;
            r_toggle     <= 1'b0;
            r_busy       <= 1'b0;
            r_pkt_ready  <= 1'b1;
        end else begin
            r_toggle    <= 1'b0;
            r_busy      <= (w_next != IDLE);
            r_pkt_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_dx   <= pkt.pkt_dx;
                r_dy   <= pkt.pkt_dy;
                r_left <= pkt.pkt_left;
            end
            if (r_state == MOVE) begin
                r_cursor_x <= w_nx;
                r_cursor_y <= w_ny;
            end
            if ((r_state == DIV) && (w_next == EMIT)) begin
                r_mouse_cell <= CELL_IDX_W'(w_row) * CELL_IDX_W'(BOARD_LENGTH)
                              + CELL_IDX_W'(w_col);
                r_toggle     <= r_left & ~r_prev_left;
            end
            if (r_state == EMIT) begin
                r_prev_left <= r_left;
            end
        end
    end
endmodule

// File: tb/tb_mouse_cell_encoder.sv
// Self-checking bench for mouse_cell_encoder: directed and random packets against a behavioural cursor model.
module tb_mouse_cell_encoder;
    localparam int BH = 3;
    localparam int BL = 3;
    localparam int CS = 4;
    localparam int XE = BL * CS;
    localparam int YE = BH * CS;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  cursor_x;
    logic [6:0]  cursor_y;
    logic [10:0] mouse_cell;
    logic        mouse_toggle;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int m_x    = 0;
    int m_y    = 0;
    int m_prev = 0;

    always #10 clock = ~clock;

    mouse_cell_encoder_if pif ();

    mouse_cell_encoder #(.BOARD_HEIGHT(BH), .BOARD_LENGTH(BL), .CELL_SIZE(CS)) dut (
        .clock       (clock),
        .reset       (reset),
        .pkt         (pif),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .mouseCell   (mouse_cell),
        .mouseToggle (mouse_toggle),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mclamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int mmove(input int cur, input int d, input int ext);
`ifdef MOUSE_CURSOR_WRAP_EN
        int dd;
        dd = mclamp(d, -(ext - 1), ext - 1);
        return (((cur + dd) % ext) + ext) % ext;
`else
        return mclamp(cur + d, 0, ext - 1);
`endif
    endfunction

    task automatic send(input int dx, input int dy, input int left);
        int ex, ey, emax, ecell, etog, k, togs, tog_k;
        ex    = mmove(m_x, dx, XE);
        ey    = mmove(m_y, -dy, YE);
        emax  = ((ex / CS) > (ey / CS)) ? (ex / CS) : (ey / CS);
        ecell = (ey / CS) * BL + (ex / CS);
        etog  = (left != 0 && m_prev == 0) ? 1 : 0;
        @(negedge clock);
        chk("ready_idle", pif.pkt_ready, 1);
        pif.pkt_valid = 1'b1;
        pif.pkt_dx    = dx[8:0];
        pif.pkt_dy    = dy[8:0];
        pif.pkt_left  = left[0];
        @(posedge clock);
        #1;
        pif.pkt_valid = 1'b0;
        chk("busy_accept", busy, 1);
        chk("ready_accept", pif.pkt_ready, 0);
        k = 0;
        togs = 0;
        tog_k = -1;
        while (busy && k < 40) begin
            @(posedge clock);
            #1;
            k++;
            if (k == 1) begin
                chk("cursor_x", cursor_x, ex);
                chk("cursor_y", cursor_y, ey);
            end
            if (mouse_toggle) begin
                togs++;
                tog_k = k;
            end
            if (k == 2 + emax) chk("cell_emit", mouse_cell, ecell);
            if (busy) chk("ready_busy", pif.pkt_ready, 0);
        end
        chk("busy_len", k, 3 + emax);
        chk("toggle_count", togs, etog);
        if (etog == 1) chk("toggle_cycle", tog_k, 2 + emax);
        chk("cell_stable", mouse_cell, ecell);
        chk("ready_after", pif.pkt_ready, 1);
        m_x    = ex;
        m_y    = ey;
        m_prev = left;
    endtask

    initial begin
        int rdx, rdy, rl, togs;
        reset         = 1'b1;
        pif.pkt_valid = 1'b0;
        pif.pkt_dx    = 9'd0;
        pif.pkt_dy    = 9'd0;
        pif.pkt_left  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cx", cursor_x, 0);
        chk("rst_cy", cursor_y, 0);
        chk("rst_cell", mouse_cell, 0);
        chk("rst_tog", mouse_toggle, 0);
        chk("rst_ready", pif.pkt_ready, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        send(5, -9, 0);
        send(0, 0, 1);
        send(0, 0, 1);
        send(0, 0, 0);
        send(100, 0, 0);
        send(-256, 0, 0);
        send(-1, 0, 0);
        send(2, 0, 0);
        send(0, 1, 0);
        send(0, -1, 0);
        send(255, 255, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rdx = int'($urandom_range(0, 511)) - 256;
                rdy = int'($urandom_range(0, 511)) - 256;
            end else begin
                rdx = int'($urandom_range(0, 30)) - 15;
                rdy = int'($urandom_range(0, 30)) - 15;
            end
            rl = int'($urandom_range(0, 1));
            send(rdx, rdy, rl);
        end

        // Reset back to origin, then abort a long packet while it is dividing.
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_x = 0;
        m_y = 0;
        m_prev = 0;
        @(negedge clock);
        pif.pkt_valid = 1'b1;
        pif.pkt_dx    = 9'd11;
        pif.pkt_dy    = 9'h1F5;
        pif.pkt_left  = 1'b1;
        @(posedge clock);
        #1;
        pif.pkt_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("midop_busy", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midop_busy0", busy, 0);
        chk("midop_ready", pif.pkt_ready, 1);
        chk("midop_cx", cursor_x, 0);
        chk("midop_cy", cursor_y, 0);
        chk("midop_cell", mouse_cell, 0);
        togs = int'(mouse_toggle);
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            togs += int'(mouse_toggle);
        end
        chk("midop_no_toggle", togs, 0);
        send(5, -9, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
